// File: rtl/cache_l1_store_ctrl.sv
// L1 data-cache store sequencer: alignment check, tag lookup, write-allocate refill from L2,
// then a single store commit into the L1 data array.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | ready for a core store; request fields latched on accept
//   S_LOOKUP | alignment/funct3 legality check and L1 tag compare
//   S_REFILL | line fetch outstanding at L2, timeout counter running
//   S_FILL   | write refilled line into data array and tag/valid
//   S_STORE  | merge core data into the line, commit pulse
//   S_ERR    | one-cycle error pulse, no array writes
module cache_l1_store_ctrl #(
  parameter int offset_size = 2,
  parameter int word_size   = 2,
  parameter int index_size  = 6,
  parameter int block_size  = 128,
  parameter int L2_TIMEOUT  = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_addr_i,
  input  logic [63:0]            req_data_i,
  input  logic [2:0]             req_funct3_i,
  input  logic                   hit_i,
  output logic [index_size-1:0]  l1_index_o,
  output logic                   l1_we_o,
  output logic                   tag_we_o,
  output logic                   write_L2_o,
  output logic [offset_size-1:0] offset_o,
  output logic [word_size-1:0]   word_o,
  output logic [2:0]             write_instruction_o,
  output logic [63:0]            data_core_o,
  output logic [block_size-1:0]  data_L2_o,
  output logic                   l2_req_o,
  output logic [31:0]            l2_addr_o,
  input  logic                   l2_valid_i,
  input  logic [block_size-1:0]  l2_data_i,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int LINE_LSB = offset_size + word_size;
  localparam int TW       = $clog2(L2_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REFILL, S_FILL, S_STORE, S_ERR
  } state_t;

  state_t                  r_state, w_next;
  logic [31:0]             r_addr;
  logic [63:0]             r_data;
  logic [2:0]              r_funct3;
  logic [block_size-1:0]   r_line;
  logic [TW-1:0]           r_timer;
  logic                    w_accept;
  logic                    w_illegal;
  logic                    w_timeout;
  logic [offset_size-1:0]  w_off;

  assign w_off     = r_addr[offset_size-1:0];
  assign w_accept  = req_valid_i && req_ready_o;
  assign w_timeout = (r_timer == '0);

  // Only SB tolerates any byte offset; SD must also sit on an even word.
  always_comb begin
    w_illegal = 1'b0;
    case (r_funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = (w_off == {offset_size{1'b1}});
      3'b010:  w_illegal = (w_off != '0);
      3'b011:  w_illegal = (w_off != '0) || r_addr[offset_size];
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_funct3 <= '0;
      r_line   <= '0;
      r_timer  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr   <= req_addr_i;
        r_data   <= req_data_i;
        r_funct3 <= req_funct3_i;
      end
      // Down-counter: loaded on the way into REFILL, terminal count at zero.
      case (r_state)
        S_LOOKUP: r_timer <= TW'(L2_TIMEOUT);
        S_REFILL: begin
          if (l2_valid_i)       r_line  <= l2_data_i;
          else if (!w_timeout)  r_timer <= r_timer - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_illegal)  w_next = S_ERR;
        else if (hit_i) w_next = S_STORE;
        else            w_next = S_REFILL;
      end
      S_REFILL: begin
        if (l2_valid_i)     w_next = S_FILL;
        else if (w_timeout) w_next = S_ERR;
      end
      S_FILL:   w_next = S_STORE;
      S_STORE:  w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o         = (r_state == S_IDLE) && !rst_i;
    l1_we_o             = 1'b0;
    tag_we_o            = 1'b0;
    write_L2_o          = 1'b0;
    l2_req_o            = 1'b0;
    done_o              = 1'b0;
    err_o               = 1'b0;
    write_instruction_o = 3'b111;
    case (r_state)
      S_REFILL: l2_req_o = 1'b1;
      S_FILL: begin
        write_L2_o = 1'b1;
        l1_we_o    = 1'b1;
        tag_we_o   = 1'b1;
      end
      S_STORE: begin
        l1_we_o             = 1'b1;
        write_instruction_o = r_funct3;
        done_o              = 1'b1;
      end
      S_ERR:   err_o = 1'b1;
      default: ;
    endcase
  end

  assign offset_o    = w_off;
  assign word_o      = r_addr[LINE_LSB-1:offset_size];
  assign l1_index_o  = r_addr[LINE_LSB+index_size-1:LINE_LSB];
  assign l2_addr_o   = {r_addr[31:LINE_LSB], {LINE_LSB{1'b0}}};
  assign data_core_o = r_data;
  assign data_L2_o   = r_line;

endmodule

// File: tb/tb_cache_l1_store_ctrl.sv
// Self-checking bench for cache_l1_store_ctrl: a transaction-level timeline model predicts
// every output per cycle; directed cases pin literal values, then randomized traffic.
module tb_cache_l1_store_ctrl;

  localparam int L2_TIMEOUT = 255;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [31:0]  req_addr_i = '0;
  logic [63:0]  req_data_i = '0;
  logic [2:0]   req_funct3_i = '0;
  logic         hit_i = 1'b0;
  logic [5:0]   l1_index_o;
  logic         l1_we_o, tag_we_o, write_L2_o;
  logic [1:0]   offset_o, word_o;
  logic [2:0]   write_instruction_o;
  logic [63:0]  data_core_o;
  logic [127:0] data_L2_o;
  logic         l2_req_o;
  logic [31:0]  l2_addr_o;
  logic         l2_valid_i = 1'b0;
  logic [127:0] l2_data_i = '0;
  logic         done_o, err_o;

  cache_l1_store_ctrl #(.L2_TIMEOUT(L2_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_funct3_i(req_funct3_i),
    .hit_i(hit_i), .l1_index_o(l1_index_o), .l1_we_o(l1_we_o), .tag_we_o(tag_we_o),
    .write_L2_o(write_L2_o), .offset_o(offset_o), .word_o(word_o),
    .write_instruction_o(write_instruction_o), .data_core_o(data_core_o),
    .data_L2_o(data_L2_o), .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o),
    .l2_valid_i(l2_valid_i), .l2_data_i(l2_data_i), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  always @(negedge clk_i) if (done_o) n_done++;

  typedef struct packed {
    logic ready, l1we, tagwe, wl2, l2req, done, err;
    logic [2:0] wi;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [2:0]  f;
    logic        hit;
    int          dly;   // L2 response delay after REFILL entry, -1 = never
  } txn_t;

  exp_t         e[int];
  logic [31:0]  m_addr = '0;
  logic [63:0]  m_data = '0;
  logic [127:0] m_line = '0;

  function automatic exp_t mk(bit rdy, bit we, bit tw, bit wl, bit rq, bit dn, bit er,
                              logic [2:0] wi);
    return {rdy, we, tw, wl, rq, dn, er, wi};
  endfunction

  function automatic bit illegal(logic [31:0] a, logic [2:0] f);
    case (f)
      3'd0:    return 1'b0;
      3'd1:    return a[1:0] == 2'b11;
      3'd2:    return a[1:0] != 2'b00;
      3'd3:    return (a[1:0] != 2'b00) || a[2];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t x;
    if (rst_i) begin
      chk("rst_ready", req_ready_o, 0);
      chk("rst_strobes", {l1_we_o, tag_we_o, write_L2_o, l2_req_o, done_o, err_o}, 0);
      chk("rst_write_instr", write_instruction_o, 3'b111);
      chk("rst_data_core", data_core_o, 0);
      chk("rst_data_L2", data_L2_o, 0);
      chk("rst_offset_word", {offset_o, word_o}, 0);
    end else begin
      x = e.exists(cyc) ? e[cyc] : mk(1, 0, 0, 0, 0, 0, 0, 3'b111);
      chk("ready", req_ready_o, x.ready);
      chk("l1_we", l1_we_o, x.l1we);
      chk("tag_we", tag_we_o, x.tagwe);
      chk("write_L2", write_L2_o, x.wl2);
      chk("l2_req", l2_req_o, x.l2req);
      chk("done", done_o, x.done);
      chk("err", err_o, x.err);
      chk("write_instr", write_instruction_o, x.wi);
      chk("offset", offset_o, m_addr[1:0]);
      chk("word", word_o, m_addr[3:2]);
      chk("index", l1_index_o, m_addr[9:4]);
      chk("data_core", data_core_o, m_data);
      chk("data_L2", data_L2_o, m_line);
      if (x.l2req) chk("l2_addr", l2_addr_o, {m_addr[31:4], 4'b0});
    end
  end

  // Present t in the current (idle) cycle and follow it to completion, one cycle past its end.
  task automatic do_txn(input txn_t t, input bit hold, input txn_t nxt, input int rst_at,
                        input bit lit, input logic [1:0] lo, input logic [1:0] lw,
                        input logic [31:0] la);
    int T, R, V, E, d0;
    bit ill, miss, inrefill;
    logic [127:0] line;
    T = cyc;
    R = T + 2;
    V = -1;
    line = '0;
    d0 = n_done;
    req_valid_i = 1'b1;
    req_addr_i = t.addr;
    req_data_i = t.data;
    req_funct3_i = t.f;
    hit_i = t.hit;
    l2_valid_i = ($urandom_range(0, 3) == 0);
    l2_data_i = rnd128();
    ill = illegal(t.addr, t.f);
    miss = !ill && !t.hit;
    e[T+1] = mk(0, 0, 0, 0, 0, 0, 0, 3'b111);
    if (ill) begin
      e[T+2] = mk(0, 0, 0, 0, 0, 0, 1, 3'b111);
      E = T + 2;
    end else if (t.hit) begin
      e[T+2] = mk(0, 1, 0, 0, 0, 1, 0, t.f);
      E = T + 2;
    end else if (t.dly >= 0) begin
      V = R + t.dly;
      for (int c = R; c <= V; c++) e[c] = mk(0, 0, 0, 0, 1, 0, 0, 3'b111);
      e[V+1] = mk(0, 1, 1, 1, 0, 0, 0, 3'b111);
      e[V+2] = mk(0, 1, 0, 0, 0, 1, 0, t.f);
      E = V + 2;
    end else begin
      for (int c = R; c <= R + L2_TIMEOUT; c++) e[c] = mk(0, 0, 0, 0, 1, 0, 0, 3'b111);
      e[R+L2_TIMEOUT+1] = mk(0, 0, 0, 0, 0, 0, 1, 3'b111);
      E = R + L2_TIMEOUT + 1;
    end
    while (cyc < E) begin
      @(posedge clk_i);
      #1;
      if (cyc == T + 1) begin
        m_addr = t.addr;
        m_data = t.data;
        if (hold) begin
          req_addr_i = nxt.addr;
          req_data_i = nxt.data;
          req_funct3_i = nxt.f;
        end else begin
          req_valid_i = 1'b0;
          req_addr_i = $urandom;
          req_data_i = {$urandom, $urandom};
        end
      end
      if (cyc == T + 2) hit_i = $urandom_range(0, 1);
      inrefill = miss && cyc >= R && (t.dly >= 0 ? cyc <= V : cyc <= R + L2_TIMEOUT);
      if (miss && t.dly >= 0 && cyc == V) begin
        line = rnd128();
        l2_valid_i = 1'b1;
        l2_data_i = line;
      end else if (inrefill) begin
        l2_valid_i = 1'b0;
      end else begin
        l2_valid_i = ($urandom_range(0, 3) == 0);
        l2_data_i = rnd128();
      end
      if (miss && t.dly >= 0 && cyc == V + 1) m_line = line;
      if (rst_at >= 0 && cyc == R + rst_at) begin
        #1 rst_i = 1'b1;
        e.delete();
        m_addr = '0;
        m_data = '0;
        m_line = '0;
        #1;
        chk("rst_mid_l2_req", l2_req_o, 0);
        chk("rst_mid_ready", req_ready_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        return;
      end
      if (lit) begin
        if (miss && cyc == R) begin
          chk("lit_l2_req", l2_req_o, 1);
          chk("lit_l2_addr", l2_addr_o, la);
        end
        if (miss && t.dly < 0 && cyc == R + L2_TIMEOUT)
          chk("lit_pre_timeout_err", {l2_req_o, err_o}, 2'b10);
        if (cyc == E) begin
          if (ill || miss && t.dly < 0) begin
            chk("lit_err", err_o, 1);
            chk("lit_err_no_we", l1_we_o, 0);
          end else begin
            chk("lit_done", done_o, 1);
            chk("lit_we", l1_we_o, 1);
            chk("lit_write_instr", write_instruction_o, t.f);
            chk("lit_offset", offset_o, lo);
            chk("lit_word", word_o, lw);
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
    chk("done_count", n_done - d0, (ill || (miss && t.dly < 0)) ? 0 : 1);
    l2_valid_i = ($urandom_range(0, 3) == 0);
    l2_data_i = rnd128();
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.addr = $urandom;
    if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
    if ($urandom_range(0, 2) == 0) t.addr[2] = 1'b0;
    t.data = {$urandom, $urandom};
    t.f = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    t.hit = ($urandom_range(0, 1) == 1);
    if ($urandom_range(0, 29) == 0) t.dly = -1;
    else t.dly = $urandom_range(0, 7);
    return t;
  endfunction

  function automatic txn_t mkt(logic [31:0] a, logic [63:0] d, logic [2:0] f, bit hit, int dly);
    txn_t t;
    t.addr = a; t.data = d; t.f = f; t.hit = hit; t.dly = dly;
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t cur, nx, z;
    bit hold;
    z = mkt(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1 chk("post_reset_ready", req_ready_o, 1);

    do_txn(mkt(32'h0000_0044, 64'hDEAD_BEEF, 3'b010, 1, 0), 0, z, -1, 1, 2'b00, 2'b01, 0);
    do_txn(mkt(32'h0000_0103, 64'h0000_00A5, 3'b000, 0, 5), 0, z, -1, 1, 2'b11, 2'b00,
           32'h0000_0100);
    do_txn(mkt(32'h0000_1237, 64'h1111, 3'b001, 1, 0), 0, z, -1, 1, 2'b11, 2'b01, 0);
    do_txn(mkt(32'h0000_2004, 64'h2222, 3'b011, 1, 0), 0, z, -1, 1, 2'b00, 2'b01, 0);
    do_txn(mkt(32'h0000_3008, 64'h3333, 3'b011, 1, 0), 0, z, -1, 1, 2'b00, 2'b10, 0);
    do_txn(mkt(32'h0000_4010, 64'h4444, 3'b010, 0, -1), 0, z, -1, 1, 2'b00, 2'b00,
           32'h0000_4010);
    do_txn(mkt(32'h0000_5022, 64'h5555, 3'b001, 0, L2_TIMEOUT), 0, z, -1, 1, 2'b10, 2'b00,
           32'h0000_5020);

    do_txn(mkt(32'h0000_6030, 64'h6666, 3'b010, 0, -1), 0, z, 3, 0, 0, 0, 0);
    repeat (2) begin @(posedge clk_i); #1; end
    l2_valid_i = 1'b1;
    l2_data_i = rnd128();
    @(posedge clk_i);
    #1 l2_valid_i = 1'b0;
    chk("late_l2_no_line", data_L2_o, 0);
    do_txn(mkt(32'h0000_7048, 64'h7777, 3'b010, 1, 0), 0, z, -1, 1, 2'b00, 2'b10, 0);

    do_txn(mkt(32'h0000_8001, 64'h8888, 3'b000, 1, 0), 1,
           mkt(32'h0000_9002, 64'h9999, 3'b001, 1, 0), -1, 0, 0, 0, 0);
    do_txn(mkt(32'h0000_9002, 64'h9999, 3'b001, 1, 0), 0, z, -1, 1, 2'b10, 2'b00, 0);

    cur = rnd_txn();
    for (int i = 0; i < 80; i++) begin
      nx = rnd_txn();
      hold = ($urandom_range(0, 2) == 0);
      do_txn(cur, hold, nx, -1, 0, 0, 0, 0);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk_i);
          #1;
          l2_valid_i = ($urandom_range(0, 3) == 0);
          l2_data_i = rnd128();
        end
      end
      cur = nx;
    end

    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
